// File: rtl/set_stream_sequencer.sv
// rtl/set_stream_sequencer.sv - host-memory set walker and template/window streamer for the NCC correlator
//
// Purpose:
//   Walks a host memory image of sets, each laid out as one header word, TEMPLATE_WORDS
//   template words and WINDOW_WORDS window words. Streams the template and window words to
//   the correlator under backpressure, writes each set's result back to host memory and
//   reports run completion or abort through out_flag.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_flag                host command word: bit16 start, bit17 abort
//   rd_req, FPGA_wr_en     read / write request, accepted on a cycle with rd_ready high
//   req_addr, write_data   request address and write data, held until accepted
//   rd_data                read data, valid RD_LATENCY cycles after an accepted read
//   flag_we, out_flag      one-cycle status strobe and the status word it publishes
//   str_data, str_tem,     streamed word with its template/window tag,
//   str_win, str_ready     transferred on a cycle with str_ready high
//   res_valid, res_ncc,    correlator result pulse for the current set
//   res_index

module set_stream_sequencer #(
   parameter int                ADDR_W         = 21,
   parameter int                DATA_W         = 32,
   parameter int                TEMPLATE_WORDS = 64,
   parameter int                WINDOW_WORDS   = 1600,
   parameter int                SET_STRIDE     = 1665,
   parameter int                RD_LATENCY     = 1,
   parameter int                MAX_SETS       = 256,
   parameter logic [ADDR_W-1:0] RESULT_BASE    = 21'h1F0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       in_flag,
   input  logic              rd_ready,
   input  logic [DATA_W-1:0] rd_data,
   output logic              rd_req,
   output logic              FPGA_wr_en,
   output logic [ADDR_W-1:0] req_addr,
   output logic [DATA_W-1:0] write_data,
   output logic              flag_we,
   output logic [31:0]       out_flag,
   output logic [DATA_W-1:0] str_data,
   output logic              str_tem,
   output logic              str_win,
   input  logic              str_ready,
   input  logic              res_valid,
   input  logic [63:0]       res_ncc,
   input  logic [11:0]       res_index
);

   localparam int DEPTH = RD_LATENCY + 2;
   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int SW    = $clog2(MAX_SETS + 1);
   localparam int WCW   = $clog2(((TEMPLATE_WORDS > WINDOW_WORDS) ? TEMPLATE_WORDS : WINDOW_WORDS) + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_HDR, S_TEMPLATE, S_WINDOW, S_DRAIN,
      S_WAIT_RES, S_WRITE, S_NEXT, S_DONE, S_ABORT
   } state_t;

   // What an in-flight read will be used for once its data lands.
   typedef enum logic [1:0] {K_HDR, K_TEM, K_WIN} kind_t;

   state_t                  state_q, state_d;
   logic [SW-1:0]           set_q, set_d;
   logic [ADDR_W-1:0]       base_q, base_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [WCW-1:0]          wcnt_q, wcnt_d;
   logic                    hdr_sent_q, hdr_sent_d;
   logic [CW-1:0]           outst_q, outst_d;
   logic [RD_LATENCY-1:0]   pipe_vld_q, pipe_vld_d;
   kind_t                   pipe_kind_q [RD_LATENCY];
   kind_t                   pipe_kind_d [RD_LATENCY];
   logic [CW-1:0]           fifo_cnt_q, fifo_cnt_d;
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic                    res_pend_q, res_pend_d;
   logic [63:0]             res_ncc_q, res_ncc_d;
   logic [11:0]             res_idx_q, res_idx_d;
   logic                    flag_we_q, flag_we_d;
   logic [31:0]             out_flag_q, out_flag_d;

   // Skid FIFO storage; the top bit tags the entry as a window word.
   logic [DATA_W:0]         fifo_mem [DEPTH];

   logic                    rd_req_c, wr_en_c, acc_rd;
   logic [ADDR_W-1:0]       req_addr_c;
   logic [DATA_W-1:0]       wr_data_c;
   kind_t                   rd_kind;
   logic [DATA_W:0]         head;
   logic                    str_valid, pop, push, room, ret_vld;
   kind_t                   ret_kind;
   logic                    start, abort;

   wire unused_in_flag = ^{in_flag[31:18], in_flag[15:0]};

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign start = in_flag[16] & ~in_flag[17];
   assign abort = in_flag[17];

   always_comb begin
      head      = fifo_mem[rd_ptr_q];
      str_valid = (fifo_cnt_q != '0) && (state_q != S_ABORT);
      pop       = str_valid && str_ready;
      ret_vld   = pipe_vld_q[RD_LATENCY-1];
      ret_kind  = pipe_kind_q[RD_LATENCY-1];
      push      = ret_vld && (ret_kind != K_HDR) && (state_q != S_IDLE) && (state_q != S_ABORT);
      // Reads in flight plus words parked must fit in the FIFO, so a stalled
      // correlator can never cause an overflow.
      room      = ({1'b0, outst_q} + {1'b0, fifo_cnt_q}) < (CW + 1)'(DEPTH);
   end

   always_comb begin
      state_d    = state_q;
      set_d      = set_q;
      base_d     = base_q;
      addr_d     = addr_q;
      wcnt_d     = wcnt_q;
      hdr_sent_d = hdr_sent_q;
      res_pend_d = res_pend_q;
      res_ncc_d  = res_ncc_q;
      res_idx_d  = res_idx_q;
      flag_we_d  = 1'b0;
      out_flag_d = out_flag_q;
      rd_req_c   = 1'b0;
      wr_en_c    = 1'b0;
      req_addr_c = addr_q;
      wr_data_c  = '0;
      rd_kind    = K_HDR;

      // A result may arrive before the set's stream has drained; hold it until WAIT_RES.
      if (res_valid && !res_pend_q &&
          (state_q inside {S_HDR, S_TEMPLATE, S_WINDOW, S_DRAIN, S_WAIT_RES})) begin
         res_pend_d = 1'b1;
         res_ncc_d  = res_ncc;
         res_idx_d  = res_index;
      end

      if (abort && (state_q != S_IDLE) && (state_q != S_ABORT)) begin
         state_d = S_ABORT;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  set_d      = '0;
                  base_d     = '0;
                  addr_d     = '0;
                  hdr_sent_d = 1'b0;
                  res_pend_d = 1'b0;
                  state_d    = S_HDR;
               end
            end
            S_HDR: begin
               if (!hdr_sent_q) begin
                  rd_req_c = 1'b1;
                  rd_kind  = K_HDR;
                  if (rd_ready) hdr_sent_d = 1'b1;
               end else if (ret_vld && (ret_kind == K_HDR)) begin
                  hdr_sent_d = 1'b0;
                  if ((rd_data[7:0] == 8'h00) || (set_q == SW'(MAX_SETS))) begin
                     state_d = S_DONE;
                  end else begin
                     addr_d  = base_q + ADDR_W'(1);
                     wcnt_d  = '0;
                     state_d = S_TEMPLATE;
                  end
               end
            end
            S_TEMPLATE: begin
               if (room) begin
                  rd_req_c = 1'b1;
                  rd_kind  = K_TEM;
                  if (rd_ready) begin
                     addr_d = addr_q + ADDR_W'(1);
                     if (wcnt_q == WCW'(TEMPLATE_WORDS - 1)) begin
                        wcnt_d  = '0;
                        state_d = S_WINDOW;
                     end else begin
                        wcnt_d = wcnt_q + WCW'(1);
                     end
                  end
               end
            end
            S_WINDOW: begin
               if (room) begin
                  rd_req_c = 1'b1;
                  rd_kind  = K_WIN;
                  if (rd_ready) begin
                     addr_d = addr_q + ADDR_W'(1);
                     if (wcnt_q == WCW'(WINDOW_WORDS - 1)) begin
                        wcnt_d  = '0;
                        state_d = S_DRAIN;
                     end else begin
                        wcnt_d = wcnt_q + WCW'(1);
                     end
                  end
               end
            end
            S_DRAIN: begin
               if ((outst_q == '0) && (fifo_cnt_q == '0)) state_d = S_WAIT_RES;
            end
            S_WAIT_RES: begin
               if (res_pend_q) begin
                  res_pend_d = 1'b0;
                  wcnt_d     = '0;
                  state_d    = S_WRITE;
               end
            end
            S_WRITE: begin
               wr_en_c    = 1'b1;
               req_addr_c = RESULT_BASE + ADDR_W'({set_q, 2'b00}) + ADDR_W'(wcnt_q);
               case (wcnt_q)
                  WCW'(0):  wr_data_c = DATA_W'(res_ncc_q[63:32]);
                  WCW'(1):  wr_data_c = DATA_W'(res_ncc_q[31:0]);
                  default:  wr_data_c = DATA_W'(res_idx_q);
               endcase
               if (rd_ready) begin
                  if (wcnt_q == WCW'(2)) begin
                     wcnt_d  = '0;
                     state_d = S_NEXT;
                  end else begin
                     wcnt_d = wcnt_q + WCW'(1);
                  end
               end
            end
            S_NEXT: begin
               set_d   = set_q + SW'(1);
               base_d  = base_q + ADDR_W'(SET_STRIDE);
               addr_d  = base_q + ADDR_W'(SET_STRIDE);
               state_d = S_HDR;
            end
            S_DONE: begin
               flag_we_d  = 1'b1;
               out_flag_d = {16'h0002, 8'h00, 8'(set_q)};
               state_d    = S_IDLE;
            end
            S_ABORT: begin
               // Reads already accepted must land (and be dropped) before the
               // next run may reuse the return path.
               if (outst_q == '0) begin
                  flag_we_d  = 1'b1;
                  out_flag_d = {16'h0004, 8'h00, 8'(set_q)};
                  state_d    = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      acc_rd  = rd_req_c && rd_ready;
      outst_d = outst_q + CW'(acc_rd) - CW'(ret_vld);

      pipe_vld_d = pipe_vld_q;
      for (int i = 0; i < RD_LATENCY; i++) pipe_kind_d[i] = pipe_kind_q[i];
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
         pipe_vld_d[i]  = pipe_vld_q[i-1];
         pipe_kind_d[i] = pipe_kind_q[i-1];
      end
      pipe_vld_d[0]  = acc_rd;
      pipe_kind_d[0] = rd_kind;

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q;
      if (state_q == S_ABORT) begin
         rd_ptr_d   = wr_ptr_q;
         fifo_cnt_d = '0;
      end else begin
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         set_q      <= '0;
         base_q     <= '0;
         addr_q     <= '0;
         wcnt_q     <= '0;
         hdr_sent_q <= 1'b0;
         outst_q    <= '0;
         pipe_vld_q <= '0;
         for (int i = 0; i < RD_LATENCY; i++) pipe_kind_q[i] <= K_HDR;
         fifo_cnt_q <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         res_pend_q <= 1'b0;
         res_ncc_q  <= '0;
         res_idx_q  <= '0;
         flag_we_q  <= 1'b0;
         out_flag_q <= '0;
      end else begin
         state_q    <= state_d;
         set_q      <= set_d;
         base_q     <= base_d;
         addr_q     <= addr_d;
         wcnt_q     <= wcnt_d;
         hdr_sent_q <= hdr_sent_d;
         outst_q    <= outst_d;
         pipe_vld_q <= pipe_vld_d;
         for (int i = 0; i < RD_LATENCY; i++) pipe_kind_q[i] <= pipe_kind_d[i];
         fifo_cnt_q <= fifo_cnt_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         res_pend_q <= res_pend_d;
         res_ncc_q  <= res_ncc_d;
         res_idx_q  <= res_idx_d;
         flag_we_q  <= flag_we_d;
         out_flag_q <= out_flag_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= {ret_kind == K_WIN, rd_data};
   end

   assign rd_req     = rd_req_c;
   assign FPGA_wr_en = wr_en_c;
   assign req_addr   = (rd_req_c || wr_en_c) ? req_addr_c : '0;
   assign write_data = wr_en_c ? wr_data_c : '0;
   assign flag_we    = flag_we_q;
   assign out_flag   = out_flag_q;
   assign str_tem    = str_valid && !head[DATA_W];
   assign str_win    = str_valid && head[DATA_W];
   assign str_data   = str_valid ? head[DATA_W-1:0] : '0;

endmodule
